// File: rtl/trdb_pkg.sv
// -----------------------------------------------------------------------------
// trdb_pkg
// Shared widths and the packed retirement entry for the trace debugger
// retirement path.
//   XLEN       address / tval width
//   ILEN       instruction word width
//   CAUSELEN   exception / interrupt cause width
//   PRIVLEN    privilege level width
//   trdb_retire_t  one retired instruction with its group context and the
//                  lost marker that tells the encoder to resynchronise.
// -----------------------------------------------------------------------------
package trdb_pkg;

    localparam int XLEN     = 32;
    localparam int ILEN     = 32;
    localparam int CAUSELEN = 5;
    localparam int PRIVLEN  = 2;

    typedef struct packed {
        logic                lost;
        logic                iexception;
        logic                interrupt;
        logic [CAUSELEN-1:0] cause;
        logic [XLEN-1:0]     tval;
        logic [PRIVLEN-1:0]  priv;
        logic [XLEN-1:0]     iaddr;
        logic [ILEN-1:0]     instr;
        logic                compressed;
    } trdb_retire_t;

endpackage

// File: rtl/trdb_lane_compact.sv
// -----------------------------------------------------------------------------
// trdb_lane_compact
// Purely combinational lane compaction. Maps a sparse per-lane valid vector
// onto a dense write order: output slot j names the source lane of the j-th
// valid lane counted in ascending lane index.
//   valid_i  [NRET]        per-lane valid
//   sel_o    [NRET][LW]    source lane for dense slot j (only slots < count_o
//                          are meaningful)
//   count_o  [CW]          popcount(valid_i)
// -----------------------------------------------------------------------------
module trdb_lane_compact #(
    parameter int NRET = 2,
    parameter int LW   = (NRET > 1) ? $clog2(NRET) : 1,
    parameter int CW   = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0]         valid_i,
    output logic [NRET-1:0][LW-1:0] sel_o,
    output logic [CW-1:0]           count_o
);

    always_comb begin
        logic [CW-1:0] run;
        logic [CW-1:0] pre [NRET];
        run = '0;
        for (int k = 0; k < NRET; k++) begin
            // pre[k] = number of valid lanes strictly below lane k, i.e. the
            // dense slot lane k lands in when it is valid.
            pre[k] = run;
            run    = run + CW'(valid_i[k]);
        end
        count_o = run;

        sel_o = '0;
        for (int j = 0; j < NRET; j++) begin
            for (int k = 0; k < NRET; k++) begin
                if (valid_i[k] && (pre[k] == CW'(j))) begin
                    sel_o[j] = LW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/trdb_retire_serializer.sv
// -----------------------------------------------------------------------------
// trdb_retire_serializer
// Collects up to NRET retired instructions per cycle into a DEPTH-entry ring
// buffer and presents them one at a time to the trace encoder.
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i, flush_i   accept groups / discard all buffered entries
//   ivalid_i, iexception_i, iaddr_i, instr_i, compressed_i   per-lane inputs
//   interrupt_i, cause_i, tval_i, priv_i                     group-shared inputs
//   out_valid_o / out_ready_i   output handshake: an entry transfers on a
//                               cycle where both are high; out_* hold stable
//                               while valid is high and ready is low
//   out_*                head entry fields; out_lost_o marks resync point
//   drop_count_o         saturating count of dropped groups
//   overflow_o           sticky: at least one group was dropped
// -----------------------------------------------------------------------------
module trdb_retire_serializer
    import trdb_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     flush_i,
    input  logic [NRET-1:0]          ivalid_i,
    input  logic [NRET-1:0]          iexception_i,
    input  logic                     interrupt_i,
    input  logic [CAUSELEN-1:0]      cause_i,
    input  logic [XLEN-1:0]          tval_i,
    input  logic [PRIVLEN-1:0]       priv_i,
    input  logic [NRET*XLEN-1:0]     iaddr_i,
    input  logic [NRET*ILEN-1:0]     instr_i,
    input  logic [NRET-1:0]          compressed_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_iexception_o,
    output logic                     out_interrupt_o,
    output logic [CAUSELEN-1:0]      out_cause_o,
    output logic [XLEN-1:0]          out_tval_o,
    output logic [PRIVLEN-1:0]       out_priv_o,
    output logic [XLEN-1:0]          out_iaddr_o,
    output logic [ILEN-1:0]          out_instr_o,
    output logic                     out_compressed_o,
    output logic                     out_lost_o,
    output logic [CNTW-1:0]          drop_count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int LW = (NRET > 1) ? $clog2(NRET) : 1;
    localparam int CW = $clog2(NRET + 1);

    trdb_retire_t mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            lost_q, lost_d;
    logic [CNTW-1:0] drop_q, drop_d;
    logic            ovf_q, ovf_d;

    logic [NRET-1:0][LW-1:0] sel;
    logic [CW-1:0]           count;
    trdb_retire_t            lane_e [NRET];
    trdb_retire_t            wr_e   [NRET];
    trdb_retire_t            head;

    logic group_ok, has_space, push, drop, pop;

    trdb_lane_compact #(
        .NRET (NRET),
        .LW   (LW),
        .CW   (CW)
    ) u_compact (
        .valid_i (ivalid_i),
        .sel_o   (sel),
        .count_o (count)
    );

    // Per-lane entry, with the group-shared fields copied into every lane.
    always_comb begin
        for (int k = 0; k < NRET; k++) begin
            lane_e[k].lost       = 1'b0;
            lane_e[k].iexception = iexception_i[k];
            lane_e[k].interrupt  = interrupt_i;
            lane_e[k].cause      = cause_i;
            lane_e[k].tval       = tval_i;
            lane_e[k].priv       = priv_i;
            lane_e[k].iaddr      = iaddr_i[k*XLEN +: XLEN];
            lane_e[k].instr      = instr_i[k*ILEN +: ILEN];
            lane_e[k].compressed = compressed_i[k];
        end
    end

    // Dense write order; only the first written entry of a group carries the
    // pending resync marker.
    always_comb begin
        for (int j = 0; j < NRET; j++) begin
            wr_e[j] = lane_e[sel[j]];
            if (j == 0) begin
                wr_e[j].lost = lost_q;
            end else begin
                wr_e[j].lost = 1'b0;
            end
        end
    end

    // Free space is judged against occupancy at the edge, without crediting a
    // pop in the same cycle, so acceptance never depends on out_ready_i.
    assign group_ok  = enable_i && (count != '0) && !flush_i;
    assign has_space = (OW'(DEPTH) - occ_q) >= OW'(count);
    assign push      = group_ok && has_space;
    assign drop      = group_ok && !has_space;
    assign pop       = out_valid_o && out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        lost_d   = lost_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            if (occ_q != '0) begin
                lost_d = 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(count);
                lost_d   = 1'b0;
            end
            if (drop) begin
                lost_d = 1'b1;
                ovf_d  = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + CNTW'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            occ_d = occ_q + (push ? OW'(count) : OW'(0)) - (pop ? OW'(1) : OW'(0));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            lost_q   <= 1'b0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            lost_q   <= lost_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; its contents are only observed while valid.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            for (int j = 0; j < NRET; j++) begin
                if (CW'(j) < count) begin
                    mem_q[wr_ptr_q + AW'(j)] <= wr_e[j];
                end
            end
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign out_valid_o      = (occ_q != '0);
    assign out_iexception_o = head.iexception;
    assign out_interrupt_o  = head.interrupt;
    assign out_cause_o      = head.cause;
    assign out_tval_o       = head.tval;
    assign out_priv_o       = head.priv;
    assign out_iaddr_o      = head.iaddr;
    assign out_instr_o      = head.instr;
    assign out_compressed_o = head.compressed;
    assign out_lost_o       = head.lost;
    assign drop_count_o     = drop_q;
    assign overflow_o       = ovf_q;

endmodule

// File: doc/trdb_retire_serializer.md
TRDB_RETIRE_SERIALIZER -- requirements
Module: trdb_retire_serializer

Interface
REQ-001 SHALL have parameter NRET, default 2: retirement lanes per cycle, legal 1..4.
REQ-002 SHALL have parameter DEPTH, default 8: buffer entries, power of two, >= 2*NRET.
REQ-003 SHALL have parameter CNTW, default 16: drop counter width.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 enable_i  in  1  accept input groups when high.
REQ-007 flush_i  in  1  discard all buffered entries.
REQ-008 ivalid_i  in  NRET  per-lane retire valid; lanes may be sparse.
REQ-009 iexception_i  in  NRET  per-lane exception flag.
REQ-010 interrupt_i  in  1; cause_i in CAUSELEN; tval_i in XLEN; priv_i in PRIVLEN: shared by the whole group.
REQ-011 iaddr_i  in  NRET*XLEN; instr_i in NRET*ILEN; compressed_i in NRET: per lane, lane k in slice k.
REQ-012 out_valid_o  out  1  head entry present.
REQ-013 out_ready_i  in  1  downstream encoder accepts head.
REQ-014 out_* outputs (iexception, interrupt, cause, tval, priv, iaddr, instr, compressed): one entry, package widths.
REQ-015 out_lost_o  out  1  entry follows one or more dropped groups (encoder must resync).
REQ-016 drop_count_o  out  CNTW  dropped groups, saturating; overflow_o out 1 sticky drop flag.

Function
REQ-017 Group accepted at edge t iff enable_i=1, popcount(ivalid_i)>0, flush_i=0, and DEPTH-occupancy(t) >= popcount(ivalid_i); free space SHALL NOT credit a same-cycle pop.
REQ-018 Accepted lanes SHALL be written in ascending lane index, invalid lanes skipped, each copying shared group fields.
REQ-019 Acceptance is all-or-nothing; partial groups SHALL never be written.
REQ-020 Otherwise-acceptable group lacking space SHALL be dropped: drop_count_o+1 (saturate at 2^CNTW-1), overflow_o=1, lost_q=1.
REQ-021 First entry of the next accepted group SHALL carry lost=1 and clear lost_q; its other entries lost=0.
REQ-022 out_valid_o = (occupancy != 0); out_* SHALL show head entry; pop when out_valid_o & out_ready_i.
REQ-023 Latency: entry written at edge t visible on outputs after t; empty-path latency exactly 1 cycle.
REQ-024 Push and pop in same cycle: occupancy += pushed-1; pointers wrap modulo DEPTH.
REQ-025 out_* SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-026 flush_i=1: occupancy and pointers to 0 next cycle, input that cycle ignored, lost_q set if occupancy was non-zero; drop_count_o, overflow_o unchanged.
REQ-027 enable_i=0: input ignored (no drop counted); buffer continues draining.

Reset
REQ-028 rst_i=1 at an edge: occupancy, pointers, lost_q, drop_count_o, overflow_o to 0; out_valid_o=0 next cycle; overrides flush_i and input, including mid-operation.
REQ-029 Storage array SHALL not require reset; out_* data undefined while out_valid_o=0.

Structure
REQ-030 XLEN, ILEN, CAUSELEN, PRIVLEN and packed entry typedef trdb_retire_t (fields of REQ-014 plus lost) SHALL live in trdb_pkg.
REQ-031 Lane compaction (sparse valid to dense write order plus popcount) SHALL be sub-module trdb_lane_compact, purely combinational.
REQ-032 Storage: DEPTH x trdb_retire_t register array, NRET write ports, one read port.

Verification (NRET=2, DEPTH=4)
REQ-033 ivalid=01, iaddr0=0x1C000080, ready=1 -> next cycle out_valid=1, iaddr=0x1C000080, lost=0; then empty.
REQ-034 ivalid=11, iaddr0=0x100, iaddr1=0x104, ready=1 -> 0x100 then 0x104 on consecutive cycles; ivalid=10 alone -> lane1 data only.
REQ-035 ready=0, three groups ivalid=11 -> occupancy 4, third dropped, drop_count=1, overflow=1; ready=1, new group 0x200/0x204 -> 0x200 has lost=1, 0x204 lost=0.
REQ-036 ivalid=01, iexception=01, cause=2, tval=0xDEADBEEF, priv=3 -> output entry carries all four values.
REQ-037 3 entries buffered, ready=0, rst_i pulsed one cycle -> out_valid=0, drop_count=0, overflow=0 next cycle; flush_i same case -> out_valid=0, next accepted entry lost=1.
